stopwatch_ctrl: RTL and testbench
=================================

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 SHALL have parameter LIMIT_MS, default 32'd3599999: elapsed-ms ceiling (59:59.999) used by the overflow stop feature.
REQ-002 SHALL have port clk, input, 1: single system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-004 SHALL have port btn_ss, input, 1: start/stop request level, already synchronous to clk.
REQ-005 SHALL have port btn_lr, input, 1: lap/reset request level, already synchronous to clk.
REQ-006 SHALL have port ms, input, 1: one-cycle 1 ms tick from the clock divider.
REQ-007 SHALL have port nrms, input, 32: live millisecond count from the counter.
REQ-008 SHALL have port ms_en, output, 1: gated tick driven to the counter's ms input.
REQ-009 SHALL have port cnt_clr, output, 1: one-cycle clear pulse to the counter.
REQ-010 SHALL have port disp, output, 32: value for display, either live nrms or the frozen lap.
REQ-011 SHALL have port state, output, 2: FSM state, IDLE=0, RUN=1, LAP=2, PAUSE=3.
REQ-012 SHALL have port ovf, output, 1: sticky flag set when the limit stop fires.

Function
REQ-013 SHALL detect requests on rising edges of btn_ss and btn_lr only, using a registered previous value; held levels produce one event.
REQ-014 SHALL, when both edges occur in the same cycle, act on btn_ss and discard btn_lr.
REQ-015 SHALL, in IDLE: on ss go to RUN; on lr stay IDLE and pulse cnt_clr.
REQ-016 SHALL, in RUN: on ss go to PAUSE; on lr capture nrms into the lap register and go to LAP.
REQ-017 SHALL, in LAP: on ss go to PAUSE with the freeze released; on lr go to RUN with the freeze released.
REQ-018 SHALL, in PAUSE: on ss go to RUN; on lr go to IDLE, pulse cnt_clr, and clear ovf and the lap register.
REQ-019 SHALL drive ms_en = ms AND (state is RUN or LAP), combinationally, with zero-cycle latency from ms.
REQ-020 SHALL drive disp = lap register in LAP, otherwise nrms (combinational passthrough).
REQ-021 SHALL assert cnt_clr for exactly one cycle, in the cycle after the triggering edge is registered.
REQ-022 SHALL take effect on state changes in the clock after the edge cycle; a tick arriving in the edge cycle is gated by the old state.

Reset
REQ-023 SHALL, with rst high at a clock edge, set state=IDLE, ms_en=0, cnt_clr=0, ovf=0, lap register=0, and the edge-detect registers to the current button levels (no false edge after reset).
REQ-024 SHALL let rst override any in-progress transition or cnt_clr pulse; disp follows nrms after reset.

Configuration
REQ-025 SHALL honour macro STOPWATCH_LIMIT_STOP_EN: when defined, in RUN or LAP with nrms >= LIMIT_MS, the FSM SHALL move to PAUSE next cycle, set ovf, release the freeze, and suppress ms_en from that cycle on.
REQ-026 SHALL, without STOPWATCH_LIMIT_STOP_EN, tie ovf to 0, ignore LIMIT_MS, and let the counter wrap freely.

Verification
REQ-027 SHALL cover: reset, then one ss edge, then 5 ms ticks -> state=1, 5 ms_en pulses, nrms=5.
REQ-028 SHALL cover: RUN at nrms=1234, lr edge -> state=2, disp=1234 frozen while nrms advances; second lr -> state=1, disp=nrms.
REQ-029 SHALL cover: RUN, ss -> PAUSE with ticks suppressed; lr -> state=0 and exactly one cnt_clr pulse; held btn_lr for 10 cycles -> one event only.
REQ-030 SHALL cover: ss and lr rising in the same cycle while in RUN -> state=3, lap register unchanged.
REQ-031 SHALL cover: with the macro and LIMIT_MS=20, run to nrms=20 -> state=3, ovf=1, no further ms_en; lr -> ovf=0, state=0.
REQ-032 SHALL cover: rst asserted in LAP with btn_lr held high -> state=0, disp=nrms, and no lap event on release of rst.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// ---------------------------------------------------------------------------
// stopwatch_ctrl
//   Start/stop and lap/reset control for a millisecond stopwatch. Detects
//   rising edges on two pre-synchronised button levels, sequences an
//   IDLE/RUN/LAP/PAUSE FSM, gates the 1 ms tick into the external counter,
//   issues a one-cycle counter clear, and freezes a lap value for display.
//   Optional feature macro: STOPWATCH_LIMIT_STOP_EN (stop at LIMIT_MS, set ovf).
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module stopwatch_ctrl #(
  parameter logic [31:0] LIMIT_MS = 32'd3599999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_ss,
  input  logic        btn_lr,
  input  logic        ms,
  input  logic [31:0] nrms,
  output logic        ms_en,
  output logic        cnt_clr,
  output logic [31:0] disp,
  output logic [1:0]  state,
  output logic        ovf
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    LAP   = 2'd2,
    PAUSE = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        ss_prev_q, lr_prev_q;
  logic [31:0] lap_q, lap_d;
  logic        cnt_clr_q, cnt_clr_d;
  logic        ovf_q, ovf_d;

  logic        w_ss_evt;
  logic        w_lr_evt;
  logic        w_counting;
  logic        w_limit_hit;

  // A simultaneous start/stop edge wins; the lap/reset edge is dropped.
  assign w_ss_evt   = btn_ss & ~ss_prev_q;
  assign w_lr_evt   = btn_lr & ~lr_prev_q & ~w_ss_evt;
  assign w_counting = (state_q == RUN) || (state_q == LAP);

`ifdef STOPWATCH_LIMIT_STOP_EN
  // Ceiling reached while the counter is live: stop and flag overflow.
  assign w_limit_hit = w_counting && (nrms >= LIMIT_MS);
`else
  // Counter wraps freely; the ceiling parameter has no effect.
  logic unused_limit;
  assign unused_limit = ^LIMIT_MS;
  assign w_limit_hit  = 1'b0;
`endif

  // State, lap, flag and edge-detect registers; reset primes the edge
  // detectors with the current levels so a held button is not an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ss_prev_q <= btn_ss;
      lr_prev_q <= btn_lr;
      lap_q     <= '0;
      cnt_clr_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ss_prev_q <= btn_ss;
      lr_prev_q <= btn_lr;
      lap_q     <= lap_d;
      cnt_clr_q <= cnt_clr_d;
      ovf_q     <= ovf_d;
    end
  end

  // Next-state decode; the limit stop pre-empts any button request.
  always_comb begin
    state_d   = state_q;
    lap_d     = lap_q;
    ovf_d     = ovf_q;
    cnt_clr_d = 1'b0;
    if (w_limit_hit) begin
      state_d = PAUSE;
      ovf_d   = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (w_ss_evt) begin
            state_d = RUN;
          end else if (w_lr_evt) begin
            cnt_clr_d = 1'b1;
          end
        end
        RUN: begin
          if (w_ss_evt) begin
            state_d = PAUSE;
          end else if (w_lr_evt) begin
            lap_d   = nrms;
            state_d = LAP;
          end
        end
        LAP: begin
          if (w_ss_evt) begin
            state_d = PAUSE;
          end else if (w_lr_evt) begin
            state_d = RUN;
          end
        end
        PAUSE: begin
          if (w_ss_evt) begin
            state_d = RUN;
          end else if (w_lr_evt) begin
            state_d   = IDLE;
            cnt_clr_d = 1'b1;
            ovf_d     = 1'b0;
            lap_d     = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign ms_en   = ms & w_counting & ~w_limit_hit;
  assign disp    = (state_q == LAP) ? lap_q : nrms;
  assign cnt_clr = cnt_clr_q;
  assign state   = state_q;
  assign ovf     = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_stopwatch_ctrl
//   Directed bench for stopwatch_ctrl with a small millisecond-counter model
//   driven by ms_en / cnt_clr and a preset hook for jumping to a count.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_stopwatch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        btn_ss = 1'b0;
  logic        btn_lr = 1'b0;
  logic        ms = 1'b0;
  logic [31:0] nrms = '0;
  logic        ms_en;
  logic        cnt_clr;
  logic [31:0] disp;
  logic [1:0]  state;
  logic        ovf;

  logic        preset = 1'b0;
  logic [31:0] preset_val = '0;
  int          en_cnt = 0;
  int          total = 0;
  int          bad = 0;
  int          base;
  int          clr_cnt;

  stopwatch_ctrl #(.LIMIT_MS(32'd20)) dut (
    .clk     (clk),
    .rst     (rst),
    .btn_ss  (btn_ss),
    .btn_lr  (btn_lr),
    .ms      (ms),
    .nrms    (nrms),
    .ms_en   (ms_en),
    .cnt_clr (cnt_clr),
    .disp    (disp),
    .state   (state),
    .ovf     (ovf)
  );

  always #5 clk = ~clk;

  // External millisecond counter model.
  always @(posedge clk) begin
    if (preset)       nrms <= preset_val;
    else if (cnt_clr) nrms <= '0;
    else if (ms_en)   nrms <= nrms + 32'd1;
    if (ms_en) en_cnt <= en_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ms_pulse(input logic exp_en);
    step();
    ms = 1'b1;
    @(negedge clk);
    chk("ms_en", 32'(ms_en), 32'(exp_en));
    step();
    ms = 1'b0;
  endtask

  task automatic press(input logic ss, input logic lr);
    step();
    btn_ss = ss;
    btn_lr = lr;
    step();
    btn_ss = 1'b0;
    btn_lr = 1'b0;
    @(negedge clk);
  endtask

  task automatic load(input logic [31:0] v);
    step();
    preset = 1'b1;
    preset_val = v;
    step();
    preset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    // Reset with a tick present: nothing may leak through.
    rst = 1'b1;
    ms = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_ms_en", 32'(ms_en), 32'd0);
    chk("rst_cnt_clr", 32'(cnt_clr), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_disp", disp, 32'd0);
    step();
    rst = 1'b0;
    ms = 1'b0;

    // Start, then five ticks.
    press(1'b1, 1'b0);
    chk("start_state", 32'(state), 32'd1);
    chk("start_cnt_clr", 32'(cnt_clr), 32'd0);
    base = en_cnt;
    repeat (5) ms_pulse(1'b1);
    @(negedge clk);
    chk("run_nrms", nrms, 32'd5);
    chk("run_pulses", 32'(en_cnt - base), 32'd5);
    chk("run_disp", disp, 32'd5);

    // Lap freeze at 1234 while the counter keeps running.
    load(32'd1234);
    chk("pre_lap_disp", disp, 32'd1234);
    press(1'b0, 1'b1);
    chk("lap_state", 32'(state), 32'd2);
    chk("lap_disp", disp, 32'd1234);
    repeat (3) ms_pulse(1'b1);
    @(negedge clk);
    chk("lap_nrms", nrms, 32'd1237);
    chk("lap_frozen", disp, 32'd1234);
    press(1'b0, 1'b1);
    chk("unlap_state", 32'(state), 32'd1);
    chk("unlap_disp", disp, 32'd1237);

    // Pause suppresses ticks; held lap/reset gives a single clear.
    press(1'b1, 1'b0);
    chk("pause_state", 32'(state), 32'd3);
    ms_pulse(1'b0);
    @(negedge clk);
    chk("pause_nrms", nrms, 32'd1237);
    step();
    btn_lr = 1'b1;
    clr_cnt = 0;
    repeat (10) begin
      @(posedge clk);
      @(negedge clk);
      if (cnt_clr) clr_cnt++;
    end
    chk("held_clr_pulses", 32'(clr_cnt), 32'd1);
    chk("held_state", 32'(state), 32'd0);
    chk("held_nrms", nrms, 32'd0);
    step();
    btn_lr = 1'b0;

    // Simultaneous edges in RUN: start/stop wins.
    press(1'b1, 1'b0);
    chk("both_pre_state", 32'(state), 32'd1);
    press(1'b1, 1'b1);
    chk("both_state", 32'(state), 32'd3);
    chk("both_cnt_clr", 32'(cnt_clr), 32'd0);
    chk("both_disp", disp, nrms);
    press(1'b0, 1'b1);
    chk("clr_state", 32'(state), 32'd0);
    chk("clr_pulse", 32'(cnt_clr), 32'd1);

    // Run up to the 20 ms ceiling.
    press(1'b1, 1'b0);
    repeat (20) ms_pulse(1'b1);
    @(negedge clk);
    chk("lim_nrms", nrms, 32'd20);
    step();
    @(negedge clk);
`ifdef STOPWATCH_LIMIT_STOP_EN
    chk("lim_state", 32'(state), 32'd3);
    chk("lim_ovf", 32'(ovf), 32'd1);
    ms_pulse(1'b0);
    @(negedge clk);
    chk("lim_hold_nrms", nrms, 32'd20);
`else
    chk("nolim_state", 32'(state), 32'd1);
    chk("nolim_ovf", 32'(ovf), 32'd0);
    ms_pulse(1'b1);
    @(negedge clk);
    chk("nolim_nrms", nrms, 32'd21);
    press(1'b1, 1'b0);
    chk("nolim_pause", 32'(state), 32'd3);
`endif
    press(1'b0, 1'b1);
    chk("ovf_clr_state", 32'(state), 32'd0);
    chk("ovf_clr_ovf", 32'(ovf), 32'd0);

    // Reset in LAP with lap/reset rising and then held.
    press(1'b1, 1'b0);
    load(32'd50);
    press(1'b0, 1'b1);
    chk("lap2_disp", disp, 32'd50);
    ms_pulse(1'b1);
    @(negedge clk);
    chk("lap2_frozen", disp, 32'd50);
    chk("lap2_nrms", nrms, 32'd51);
    step();
    btn_lr = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rstlap_state", 32'(state), 32'd0);
    chk("rstlap_disp", disp, 32'd51);
    clr_cnt = 0;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      if (cnt_clr) clr_cnt++;
    end
    chk("rstlap_no_event", 32'(clr_cnt), 32'd0);
    chk("rstlap_state2", 32'(state), 32'd0);
    chk("rstlap_disp2", disp, nrms);
    step();
    btn_lr = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
